// File: rtl/axi_read_arbiter_if.sv
// Signal bundle between four AXI read masters, the shared slave and the read arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface axi_read_arbiter_if;
    logic       s0_ARVALID;
    logic       s1_ARVALID;
    logic       s2_ARVALID;
    logic       s3_ARVALID;
    logic       s2m_ARVALID;
    logic       s2m_ARREADY;
    logic [7:0] s2m_ARLEN;
    logic       s2m_RVALID;
    logic       s2m_RREADY;
    logic       s2m_RLAST;
    logic       s0_rgrnt;
    logic       s1_rgrnt;
    logic       s2_rgrnt;
    logic       s3_rgrnt;
    logic       rd_busy;
    logic       len_err;

    modport slave (
        input  s0_ARVALID, s1_ARVALID, s2_ARVALID, s3_ARVALID,
        input  s2m_ARVALID, s2m_ARREADY, s2m_ARLEN,
        input  s2m_RVALID, s2m_RREADY, s2m_RLAST,
        output s0_rgrnt, s1_rgrnt, s2_rgrnt, s3_rgrnt, rd_busy, len_err
    );

    modport master (
        output s0_ARVALID, s1_ARVALID, s2_ARVALID, s3_ARVALID,
        output s2m_ARVALID, s2m_ARREADY, s2m_ARLEN,
        output s2m_RVALID, s2m_RREADY, s2m_RLAST,
        input  s0_rgrnt, s1_rgrnt, s2_rgrnt, s3_rgrnt, rd_busy, len_err
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Four-master AXI read-channel arbiter: grants one master per burst and holds it
// from address phase until the RLAST beat, flagging burst-length/RLAST mismatches.
module axi_read_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    axi_read_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic [1:0] r_last, w_last_nxt;
    logic [7:0] r_beat_cnt, w_beat_cnt_nxt;
    logic       r_busy;
    logic       r_len_err, w_len_err_nxt;
    logic [3:0] w_req;
    logic [1:0] w_win, w_idx;
    logic       w_win_vld;
    logic       w_beat;

    assign w_req  = {bus.s3_ARVALID, bus.s2_ARVALID, bus.s1_ARVALID, bus.s0_ARVALID};
    assign w_beat = bus.s2m_RVALID & bus.s2m_RREADY;

    // Walk the search order backwards so the earliest candidate is the last one kept.
    always_comb begin
        w_win     = 2'd0;
        w_win_vld = 1'b0;
        w_idx     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = RR_EN ? 2'(int'(r_last) + k) : 2'(k - 1);
            if (w_req[w_idx]) begin
                w_win     = w_idx;
                w_win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_nxt     = r_last;
        w_beat_cnt_nxt = r_beat_cnt;
        w_len_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_grant_nxt = 4'b0001 << w_win;
                    w_last_nxt  = w_win;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (bus.s2m_ARVALID && bus.s2m_ARREADY) begin
                    w_beat_cnt_nxt = bus.s2m_ARLEN;
                    w_state_nxt    = DATA;
                end
            end
            DATA: begin
                if (w_beat) begin
                    w_beat_cnt_nxt = (r_beat_cnt == 8'd0) ? 8'd0 : r_beat_cnt - 8'd1;
                    if (bus.s2m_RLAST) begin
                        w_len_err_nxt = (r_beat_cnt != 8'd0);
                        w_grant_nxt   = 4'b0000;
                        w_state_nxt   = IDLE;
                    end else begin
                        // Burst overran its length: flag it but keep waiting for RLAST.
                        w_len_err_nxt = (r_beat_cnt == 8'd0);
                    end
                end
            end
            default: begin
                w_grant_nxt = 4'b0000;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_grant    <= 4'b0000;
            r_last     <= 2'd3;
            r_beat_cnt <= 8'd0;
            r_busy     <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_busy     <= |w_grant_nxt;
            r_len_err  <= w_len_err_nxt;
        end
    end

    assign bus.s0_rgrnt = r_grant[0];
    assign bus.s1_rgrnt = r_grant[1];
    assign bus.s2_rgrnt = r_grant[2];
    assign bus.s3_rgrnt = r_grant[3];
    assign bus.rd_busy  = r_busy;
    assign bus.len_err  = r_len_err;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: a round-robin and a fixed-priority instance share
// every stimulus; directed vector table, burst sequences, async reset and random traffic.
module tb_axi_read_arbiter;
    typedef struct packed {
        logic [3:0] arv;
        logic       arvalid;
        logic       arready;
        logic [7:0] arlen;
        logic       rvalid;
        logic       rready;
        logic       rlast;
    } in_t;

    typedef struct {
        in_t        in;
        logic [3:0] g_rr;
        logic [3:0] g_fx;
        logic       err;
    } vec_t;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_err;

    axi_read_arbiter_if if_rr();
    axi_read_arbiter_if if_fx();

    axi_read_arbiter #(.RR_EN(1'b1)) u_rr (.clk(clk), .rstn(rstn), .bus(if_rr));
    axi_read_arbiter #(.RR_EN(1'b0)) u_fx (.clk(clk), .rstn(rstn), .bus(if_fx));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = round-robin, 1 = fixed priority
    int   m_owner[2];
    int   m_last[2];
    int   m_rem[2];
    bit   m_addr[2];
    logic m_err[2];

    function automatic in_t mk(logic [3:0] arv, logic hs, logic [7:0] len, logic beat, logic last);
        in_t v;
        v.arv     = arv;
        v.arvalid = hs;
        v.arready = hs;
        v.arlen   = len;
        v.rvalid  = beat;
        v.rready  = beat;
        v.rlast   = last;
        return v;
    endfunction

    task automatic drive(input in_t v);
        {if_rr.s3_ARVALID, if_rr.s2_ARVALID, if_rr.s1_ARVALID, if_rr.s0_ARVALID} = v.arv;
        {if_fx.s3_ARVALID, if_fx.s2_ARVALID, if_fx.s1_ARVALID, if_fx.s0_ARVALID} = v.arv;
        if_rr.s2m_ARVALID = v.arvalid; if_fx.s2m_ARVALID = v.arvalid;
        if_rr.s2m_ARREADY = v.arready; if_fx.s2m_ARREADY = v.arready;
        if_rr.s2m_ARLEN   = v.arlen;   if_fx.s2m_ARLEN   = v.arlen;
        if_rr.s2m_RVALID  = v.rvalid;  if_fx.s2m_RVALID  = v.rvalid;
        if_rr.s2m_RREADY  = v.rready;  if_fx.s2m_RREADY  = v.rready;
        if_rr.s2m_RLAST   = v.rlast;   if_fx.s2m_RLAST   = v.rlast;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] out_rr();
        return {if_rr.s3_rgrnt, if_rr.s2_rgrnt, if_rr.s1_rgrnt, if_rr.s0_rgrnt, if_rr.rd_busy, if_rr.len_err};
    endfunction

    function automatic logic [5:0] out_fx();
        return {if_fx.s3_rgrnt, if_fx.s2_rgrnt, if_fx.s1_rgrnt, if_fx.s0_rgrnt, if_fx.rd_busy, if_fx.len_err};
    endfunction

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got grant/busy/err=%b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_both(input string nm, input logic [3:0] g_rr, input logic [3:0] g_fx,
                            input logic e_rr, input logic e_fx);
        chk({nm, "_rr"}, out_rr(), {g_rr, |g_rr, e_rr});
        chk({nm, "_fx"}, out_fx(), {g_fx, |g_fx, e_fx});
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(mk(4'b0000, 1'b0, 8'd0, 1'b0, 1'b0));
        step();
        step();
        chk_both("reset_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
        rstn = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_last[m]  = 3;
            m_rem[m]   = 0;
            m_addr[m]  = 1'b0;
            m_err[m]   = 1'b0;
        end
    endtask

    function automatic int pick(logic [3:0] req, int last, bit rr);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = rr ? (last + 1 + k) % 4 : k;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock of transaction-level behaviour: who owns the bus and how many beats remain
    task automatic model_step(input int m, input in_t v);
        m_err[m] = 1'b0;
        if (m_owner[m] < 0) begin
            int w;
            w = pick(v.arv, m_last[m], (m == 0));
            if (w >= 0) begin
                m_owner[m] = w;
                m_last[m]  = w;
                m_addr[m]  = 1'b1;
            end
        end else if (m_addr[m]) begin
            if (v.arvalid && v.arready) begin
                m_addr[m] = 1'b0;
                m_rem[m]  = int'(v.arlen);
            end
        end else if (v.rvalid && v.rready) begin
            if (v.rlast) begin
                m_err[m]   = (m_rem[m] != 0);
                m_owner[m] = -1;
            end else begin
                m_err[m] = (m_rem[m] == 0);
            end
            if (m_rem[m] > 0) m_rem[m]--;
        end
    endtask

    function automatic logic [3:0] m_grant(int m);
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner[m] >= 0) g[m_owner[m]] = 1'b1;
        return g;
    endfunction

    vec_t tbl[21];

    initial begin
        n_chk = 0;
        n_err = 0;
        rstn  = 1'b0;
        drive(mk(4'b0000, 1'b0, 8'd0, 1'b0, 1'b0));

        tbl[0]  = '{mk(4'b0001, 1'b0, 8'd0, 1'b0, 1'b0), 4'b0001, 4'b0001, 1'b0};
        tbl[1]  = '{mk(4'b0000, 1'b1, 8'd3, 1'b0, 1'b0), 4'b0001, 4'b0001, 1'b0};
        tbl[2]  = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0), 4'b0001, 4'b0001, 1'b0};
        tbl[3]  = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0), 4'b0001, 4'b0001, 1'b0};
        tbl[4]  = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0), 4'b0001, 4'b0001, 1'b0};
        tbl[5]  = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b1), 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b1), 4'b0000, 4'b0000, 1'b0};
        tbl[7]  = '{mk(4'b0010, 1'b0, 8'd0, 1'b0, 1'b0), 4'b0010, 4'b0010, 1'b0};
        tbl[8]  = '{mk(4'b0000, 1'b1, 8'd1, 1'b0, 1'b0), 4'b0010, 4'b0010, 1'b0};
        tbl[9]  = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b1), 4'b0000, 4'b0000, 1'b1};
        tbl[10] = '{mk(4'b0000, 1'b0, 8'd0, 1'b0, 1'b0), 4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{mk(4'b0100, 1'b0, 8'd0, 1'b0, 1'b0), 4'b0100, 4'b0100, 1'b0};
        tbl[12] = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b1), 4'b0100, 4'b0100, 1'b0};
        tbl[13] = '{mk(4'b0000, 1'b1, 8'd0, 1'b0, 1'b0), 4'b0100, 4'b0100, 1'b0};
        tbl[14] = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0), 4'b0100, 4'b0100, 1'b1};
        tbl[15] = '{mk(4'b0000, 1'b0, 8'd0, 1'b0, 1'b0), 4'b0100, 4'b0100, 1'b0};
        tbl[16] = '{mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b1), 4'b0000, 4'b0000, 1'b0};
        tbl[17] = '{mk(4'b1111, 1'b0, 8'd0, 1'b0, 1'b0), 4'b1000, 4'b0001, 1'b0};
        tbl[18] = '{mk(4'b1111, 1'b1, 8'd0, 1'b0, 1'b0), 4'b1000, 4'b0001, 1'b0};
        tbl[19] = '{mk(4'b1111, 1'b0, 8'd0, 1'b1, 1'b1), 4'b0000, 4'b0000, 1'b0};
        tbl[20] = '{mk(4'b1111, 1'b0, 8'd0, 1'b0, 1'b0), 4'b0001, 4'b0001, 1'b0};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].in);
            step();
            chk_both($sformatf("vec%0d", i), tbl[i].g_rr, tbl[i].g_fx, tbl[i].err, tbl[i].err);
        end

        // All four requesting, single-beat bursts: round-robin rotates, fixed stays on s0
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e_rr;
            e_rr = 4'b0001 << (k % 4);
            drive(mk(4'b1111, 1'b0, 8'd0, 1'b0, 1'b0));
            step();
            chk_both($sformatf("rot_grant%0d", k), e_rr, 4'b0001, 1'b0, 1'b0);
            drive(mk(4'b1111, 1'b1, 8'd0, 1'b0, 1'b0));
            step();
            drive(mk(4'b1111, 1'b0, 8'd0, 1'b1, 1'b1));
            step();
            chk_both($sformatf("rot_end%0d", k), 4'b0000, 4'b0000, 1'b0, 1'b0);
        end

        // s1 and s3 always requesting: fixed never serves s3, round-robin alternates
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic [3:0] e_rr;
            e_rr = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            drive(mk(4'b1010, 1'b0, 8'd0, 1'b0, 1'b0));
            step();
            chk_both($sformatf("fix_grant%0d", k), e_rr, 4'b0010, 1'b0, 1'b0);
            drive(mk(4'b1010, 1'b1, 8'd0, 1'b0, 1'b0));
            step();
            drive(mk(4'b1010, 1'b0, 8'd0, 1'b1, 1'b1));
            step();
        end

        // Reset asserted between edges while in DATA
        do_reset();
        drive(mk(4'b0001, 1'b0, 8'd0, 1'b0, 1'b0));
        step();
        drive(mk(4'b0000, 1'b1, 8'd5, 1'b0, 1'b0));
        step();
        drive(mk(4'b0000, 1'b0, 8'd0, 1'b1, 1'b0));
        step();
        chk_both("pre_async", 4'b0001, 4'b0001, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk_both("async_drop", 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(mk(4'b0101, 1'b0, 8'd0, 1'b0, 1'b0));
        step();
        rstn = 1'b1;
        step();
        chk_both("post_reset", 4'b0001, 4'b0001, 1'b0, 1'b0);

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_t v;
            v.arv     = 4'($urandom_range(0, 15));
            v.arvalid = 1'($urandom % 2);
            v.arready = 1'($urandom % 2);
            v.arlen   = 8'($urandom_range(0, 3));
            v.rvalid  = 1'($urandom % 2);
            v.rready  = 1'($urandom_range(0, 3) != 0);
            v.rlast   = 1'($urandom_range(0, 2) == 0);
            drive(v);
            model_step(0, v);
            model_step(1, v);
            step();
            chk_both($sformatf("rand%0d", c), m_grant(0), m_grant(1), m_err[0], m_err[1]);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
